// File: rtl/pigasus_to_axis.sv
// Turns the matcher's Avalon-style user stream back into AXI Stream, with the first byte in lane 0 and one output beat per cycle.
// Optional build macro PIGASUS_AXIS_STATS_EN enables the packet and byte counters.
module pigasus_to_axis #(
  parameter int BYTE_COUNT = 16,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BYTE_COUNT*8-1:0]       in_usr_data,
  input  logic                          in_usr_valid,
  output logic                          in_usr_ready,
  input  logic                          in_usr_sop,
  input  logic                          in_usr_eop,
  input  logic [$clog2(BYTE_COUNT)-1:0] in_usr_empty,
  output logic [BYTE_COUNT*8-1:0]       m_axis_tdata,
  output logic [BYTE_COUNT-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          err_orphan,
  output logic                          err_resop,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic [31:0]                   pkt_count,
  output logic [47:0]                   byte_count
);
  localparam int DW = BYTE_COUNT * 8;

  typedef enum logic {IDLE, PKT} state_t;
  state_t state;

  logic                  in_fire, fwd, orphan, resop, main_free, skid_nxt;
  logic                  skid_vld, skid_last;
  logic [DW-1:0]         skid_dat, beat_dat;
  logic [BYTE_COUNT-1:0] skid_keep, beat_keep;

  // Avalon carries the first byte in the MSB lane; AXI wants it in lane 0.
  always_comb begin
    beat_dat = '0;
    for (int k = 0; k < BYTE_COUNT; k++)
      beat_dat[k*8 +: 8] = in_usr_data[(BYTE_COUNT-1-k)*8 +: 8];
    beat_keep = in_usr_eop ? ({BYTE_COUNT{1'b1}} >> in_usr_empty) : {BYTE_COUNT{1'b1}};
  end

  assign in_fire   = in_usr_valid & in_usr_ready;
  assign fwd       = in_fire & ((state == PKT) | in_usr_sop);
  assign orphan    = in_fire & (state == IDLE) & ~in_usr_sop;
  assign resop     = in_fire & (state == PKT) & in_usr_sop;
  assign main_free = ~m_axis_tvalid | m_axis_tready;
  // Orphans never take buffer space, so only forwarded beats can fill the skid.
  assign skid_nxt  = skid_vld ? ~main_free : (fwd & ~main_free);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (in_fire) begin
      if (state == IDLE) begin
        if (in_usr_sop && !in_usr_eop) state <= PKT;
      end else if (in_usr_eop) begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_usr_ready  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      skid_vld      <= 1'b0;
      skid_dat      <= '0;
      skid_keep     <= '0;
      skid_last     <= 1'b0;
      err_orphan    <= 1'b0;
      err_resop     <= 1'b0;
      err_count     <= '0;
    end else begin
      in_usr_ready <= ~skid_nxt;
      skid_vld     <= skid_nxt;
      if (main_free) begin
        m_axis_tvalid <= skid_vld | fwd;
        if (skid_vld) begin
          m_axis_tdata <= skid_dat;
          m_axis_tkeep <= skid_keep;
          m_axis_tlast <= skid_last;
        end else if (fwd) begin
          m_axis_tdata <= beat_dat;
          m_axis_tkeep <= beat_keep;
          m_axis_tlast <= in_usr_eop;
        end
      end else if (fwd) begin
        skid_dat  <= beat_dat;
        skid_keep <= beat_keep;
        skid_last <= in_usr_eop;
      end
      err_orphan <= orphan;
      err_resop  <= resop;
      if ((orphan || resop) && (err_count != {ERR_CNT_W{1'b1}}))
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end

`ifdef PIGASUS_AXIS_STATS_EN
  logic [47:0] keep_ones;
  always_comb begin
    keep_ones = '0;
    for (int i = 0; i < BYTE_COUNT; i++)
      keep_ones = keep_ones + 48'(m_axis_tkeep[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count  <= '0;
      byte_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      if (m_axis_tlast) pkt_count <= pkt_count + 32'd1;
      byte_count <= byte_count + keep_ones;
    end
  end
`else
  assign pkt_count  = '0;
  assign byte_count = '0;
`endif

endmodule

// File: tb/tb_pigasus_to_axis.sv
// Directed bench for pigasus_to_axis (BYTE_COUNT=16): framing, lane swap, skid stall, errors, reset, stats.
module tb_pigasus_to_axis;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_usr_data;
  logic         in_usr_valid, in_usr_ready, in_usr_sop, in_usr_eop;
  logic [3:0]   in_usr_empty;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic         err_orphan, err_resop;
  logic [15:0]  err_count;
  logic [31:0]  pkt_count;
  logic [47:0]  byte_count;

  int vectors = 0;
  int miscompares = 0;

`ifdef PIGASUS_AXIS_STATS_EN
  localparam logic [31:0] EXP_PKTS  = 32'd2;
  localparam logic [47:0] EXP_BYTES = 48'd49;
`else
  localparam logic [31:0] EXP_PKTS  = 32'd0;
  localparam logic [47:0] EXP_BYTES = 48'd0;
`endif

  pigasus_to_axis #(.BYTE_COUNT(16), .ERR_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_usr_data(in_usr_data), .in_usr_valid(in_usr_valid), .in_usr_ready(in_usr_ready),
    .in_usr_sop(in_usr_sop), .in_usr_eop(in_usr_eop), .in_usr_empty(in_usr_empty),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .err_orphan(err_orphan), .err_resop(err_resop), .err_count(err_count),
    .pkt_count(pkt_count), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Packet byte k sits in the MSB-first lane on input.
  function automatic logic [127:0] mk_in(input logic [7:0] base);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[(15-k)*8 +: 8] = base + 8'(k);
    return r;
  endfunction

  function automatic logic [127:0] mk_out(input logic [7:0] base);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [3:0] emp, input logic [7:0] base);
    in_usr_valid = v;
    in_usr_sop   = s;
    in_usr_eop   = e;
    in_usr_empty = emp;
    in_usr_data  = mk_in(base);
  endtask

  logic trd  [11] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  logic ev   [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int   eidx [11] = '{0, 1, 1, 1, 2, 3, 4, 5, 6, 7, 0};
  logic erd  [11] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    int  idx;
    logic acc;
    rst_n = 1'b0;
    m_axis_tready = 1'b1;
    drive(0, 0, 0, 0, 8'h00);
    #3;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_ready", in_usr_ready, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_pkts", pkt_count, 0);
    chk("rst_bytes", byte_count, 0);
    #9 rst_n = 1'b1;
    step();
    chk("ready_after_rst", in_usr_ready, 1);

    // 3-beat packet, empty=5 on the last beat
    drive(1, 1, 0, 0, 8'h00); step();
    chk("p1b0_vld", m_axis_tvalid, 1);
    chk("p1b0_dat", m_axis_tdata, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("p1b0_keep", m_axis_tkeep, 16'hFFFF);
    chk("p1b0_last", m_axis_tlast, 0);
    drive(1, 0, 0, 0, 8'h10); step();
    chk("p1b1_dat", m_axis_tdata, mk_out(8'h10));
    chk("p1b1_last", m_axis_tlast, 0);
    drive(1, 0, 1, 5, 8'h20); step();
    chk("p1b2_dat", m_axis_tdata, mk_out(8'h20));
    chk("p1b2_keep", m_axis_tkeep, 16'h07FF);
    chk("p1b2_last", m_axis_tlast, 1);
    drive(0, 0, 0, 0, 8'h00); step();
    chk("p1_drain", m_axis_tvalid, 0);

    // single-beat packet, empty=15
    drive(1, 1, 1, 15, 8'h40); step();
    chk("p2_vld", m_axis_tvalid, 1);
    chk("p2_dat", m_axis_tdata, mk_out(8'h40));
    chk("p2_keep", m_axis_tkeep, 16'h0001);
    chk("p2_last", m_axis_tlast, 1);
    drive(0, 0, 0, 0, 8'h00); step();

    // orphan beat in IDLE, then a clean packet
    drive(1, 0, 0, 0, 8'h50); step();
    chk("orph_vld", m_axis_tvalid, 0);
    chk("orph_pulse", err_orphan, 1);
    drive(0, 0, 0, 0, 8'h00); step();
    chk("orph_pulse_end", err_orphan, 0);
    chk("orph_cnt", err_count, 1);
    drive(1, 1, 1, 0, 8'h60); step();
    chk("p3_vld", m_axis_tvalid, 1);
    chk("p3_dat", m_axis_tdata, mk_out(8'h60));
    chk("p3_last", m_axis_tlast, 1);
    drive(0, 0, 0, 0, 8'h00); step();

    // two back-to-back 4-beat packets with a two-cycle downstream stall
    idx = 0;
    drive(1, 1, 0, 0, 8'h00);
    for (int e = 0; e < 11; e++) begin
      m_axis_tready = trd[e];
      acc = in_usr_valid & in_usr_ready;
      step();
      if (acc) idx++;
      drive(idx < 8, (idx % 4) == 0, (idx % 4) == 3, 0, 8'(idx * 16));
      chk($sformatf("b2b_vld_%0d", e), m_axis_tvalid, ev[e]);
      chk($sformatf("b2b_rdy_%0d", e), in_usr_ready, erd[e]);
      if (ev[e]) begin
        chk($sformatf("b2b_dat_%0d", e), m_axis_tdata, mk_out(8'(eidx[e] * 16)));
        chk($sformatf("b2b_last_%0d", e), m_axis_tlast, (eidx[e] % 4) == 3);
      end
    end
    m_axis_tready = 1'b1;

    // sop re-asserted on beat 2 of 3
    drive(1, 1, 0, 0, 8'h90); step();
    chk("rs_b0_pulse", err_resop, 0);
    drive(1, 1, 0, 0, 8'hA0); step();
    chk("rs_pulse", err_resop, 1);
    chk("rs_cnt", err_count, 2);
    chk("rs_b1_dat", m_axis_tdata, mk_out(8'hA0));
    chk("rs_b1_last", m_axis_tlast, 0);
    drive(1, 0, 1, 0, 8'hB0); step();
    chk("rs_pulse_end", err_resop, 0);
    chk("rs_b2_dat", m_axis_tdata, mk_out(8'hB0));
    chk("rs_b2_last", m_axis_tlast, 1);
    drive(0, 0, 0, 0, 8'h00); step();

    // reset mid-packet with main and skid both full
    m_axis_tready = 1'b0;
    drive(1, 1, 0, 0, 8'hC0); step();
    chk("mr_vld", m_axis_tvalid, 1);
    drive(1, 0, 0, 0, 8'hD0); step();
    chk("mr_skid_full", in_usr_ready, 0);
    #2 rst_n = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
    #1;
    chk("mr_rst_vld", m_axis_tvalid, 0);
    chk("mr_rst_rdy", in_usr_ready, 0);
    chk("mr_rst_cnt", err_count, 0);
    #2 rst_n = 1'b1;
    m_axis_tready = 1'b1;
    step();
    chk("mr_rdy_back", in_usr_ready, 1);
    chk("mr_vld_after", m_axis_tvalid, 0);
    drive(1, 0, 1, 0, 8'hE0); step();
    chk("mr_orph_vld", m_axis_tvalid, 0);
    chk("mr_orph_pulse", err_orphan, 1);
    chk("mr_orph_cnt", err_count, 1);

    // 17-byte and 32-byte packets for the stats counters
    drive(1, 1, 0, 0, 8'h00); step();
    drive(1, 0, 1, 15, 8'h10); step();
    chk("st_b1_keep", m_axis_tkeep, 16'h0001);
    drive(1, 1, 0, 0, 8'h20); step();
    drive(1, 0, 1, 0, 8'h30); step();
    drive(0, 0, 0, 0, 8'h00); step();
    chk("st_pkts", pkt_count, EXP_PKTS);
    chk("st_bytes", byte_count, EXP_BYTES);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pigasus_to_axis.md
Name: pigasus_to_axis

Overview:
- Converts the string matcher's Avalon-style user stream (sop/eop/empty, first byte in the MSB lane) back into an AXI Stream (tkeep/tlast, first byte in lane 0).
- Sits after the matcher/port-group output, opposite the AXI-to-matcher ingress shim.
- Enforces packet framing, drops orphan beats, and provides a one-deep skid buffer so both sides keep full throughput.

Parameters:
- BYTE_COUNT, 16: bytes per beat; power of two, ≥ 2.
- ERR_CNT_W, 16: width of the saturating framing-error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_usr_data  in  BYTE_COUNT*8  beat; byte 0 of the packet is in [BYTE_COUNT*8-1 -: 8]
- in_usr_valid  in  1  beat valid
- in_usr_ready  out  1  beat accepted when valid&ready
- in_usr_sop  in  1  first beat of packet
- in_usr_eop  in  1  last beat of packet
- in_usr_empty  in  $clog2(BYTE_COUNT)  unused trailing bytes on eop beat
- m_axis_tdata  out  BYTE_COUNT*8  byte 0 of the packet is in [7:0]
- m_axis_tkeep  out  BYTE_COUNT  byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last beat
- m_axis_tready  in  1  downstream ready
- err_orphan  out  1  one-cycle pulse: beat dropped in IDLE without sop
- err_resop  out  1  one-cycle pulse: sop seen inside a packet
- err_count  out  ERR_CNT_W  saturating count of both errors
- pkt_count  out  32  packets emitted (stats only)
- byte_count  out  48  bytes emitted (stats only)

Behaviour:
- Reset is asynchronous on rst_n low and takes effect immediately. Reset values:
  - All outputs 0, including in_usr_ready.
  - FSM = IDLE; skid buffer and main output register empty.
- in_usr_ready rises on the first clk edge after rst_n deasserts.
- Lane mapping: m_axis_tdata[(k-1)*8 +: 8] = in_usr_data[(BYTE_COUNT-k)*8 +: 8] for k = 1..BYTE_COUNT.
- tkeep:
  - On an eop beat: tkeep = {BYTE_COUNT{1'b1}} >> in_usr_empty.
  - Otherwise tkeep is all ones and in_usr_empty is ignored.
  - tlast = eop.
- FSM (advances only on input handshake):
  - IDLE + sop&!eop: forward the beat, go to PKT.
  - IDLE + sop&eop: forward the beat, stay in IDLE.
  - IDLE + !sop: consume and discard the beat; pulse err_orphan; no output beat.
  - PKT + !eop: forward the beat.
  - PKT + eop: forward the beat with tlast, go to IDLE.
  - PKT + sop: pulse err_resop; treat the beat as a continuation (sop ignored); eop still honoured.
- Buffering: main output register plus one skid register.
  - Latency from input handshake to m_axis_tvalid: 1 cycle.
  - in_usr_ready is registered and equals !skid_valid.
  - If the main register holds data and m_axis_tready=0 when a beat is accepted, the beat goes to skid.
  - When main drains, skid moves to main in the same cycle.
  - With m_axis_tready held at 1, in_usr_ready stays 1: 1 beat/cycle.
- AXI rules: while tvalid=1 and tready=0, tdata/tkeep/tlast hold stable. tvalid never drops without a handshake.
- Dropped (orphan) beats never occupy buffer space and are accepted even if the main register is stalled, provided skid is empty.
- err_count increments by 1 per error pulse, saturates at all ones, and both pulses in one cycle are impossible.
- Reset mid-packet discards all buffered beats; the next packet must begin with sop.

Optional Feature:
- Macro: PIGASUS_AXIS_STATS_EN.
- Defined:
  - pkt_count increments on each output handshake with tlast=1.
  - byte_count adds popcount(m_axis_tkeep) on each output handshake.
  - Both counters wrap and reset to 0.
- Undefined: pkt_count and byte_count are tied to 0 and no counter logic is built.

Test Plan:
- Single 3-beat packet, empty=5 on eop, tready=1 -> 3 beats out, 1-cycle latency; last tkeep=16'h07FF, tlast only on beat 3; lanes byte-reversed (in 0x00..0F -> tdata[7:0]=0x00).
- One-beat packet sop&eop, empty=15 -> single beat, tkeep=16'h0001, tlast=1, FSM back in IDLE.
- Beat with valid=1, sop=0 in IDLE -> no output, err_orphan pulse, err_count=1; next sop packet passes intact.
- Back-to-back 4-beat packets; tready toggled 1,0,0,1 -> skid fills, in_usr_ready=0 for exactly the stalled cycles, no beat lost or reordered, output data held stable under stall.
- sop re-asserted on beat 2 of 3 -> err_resop pulse, 3 beats out with tlast on beat 3; rst_n low mid-packet -> tvalid=0 immediately, ready=1 one cycle after release.
- With PIGASUS_AXIS_STATS_EN: packets of 17 and 32 bytes -> pkt_count=2, byte_count=49. Without the macro -> both counters 0.
